// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, encoded index and
// an optional per-tenure hold limit that forces rotation.
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       forced_rel
);

   localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] idx_q, idx_d;
   logic       forced_q, forced_d;

   logic [2:0] owner_nxt;
   logic [7:0] others;

   // First set bit of v, scanning upward from p with wraparound.
   function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] p);
      logic [2:0] r;
      logic [2:0] j;
      logic       found;
      r     = p;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         j = p + 3'(i);
         if (!found && v[j]) begin
            r     = j;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   assign owner_nxt = idx_q + 3'd1;
   assign others    = req & ~grant_q;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      hold_d   = hold_q;
      grant_d  = grant_q;
      idx_d    = idx_q;
      forced_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req != 8'h00) begin
               idx_d   = pick(req, ptr_q);
               grant_d = 8'h01 << idx_d;
               hold_d  = 8'd1;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (!req[idx_q]) begin
               ptr_d = owner_nxt;
               if (others != 8'h00) begin
                  idx_d   = pick(others, owner_nxt);
                  grant_d = 8'h01 << idx_d;
                  hold_d  = 8'd1;
               end else begin
                  idx_d   = 3'd0;
                  grant_d = 8'h00;
                  hold_d  = 8'd0;
                  state_d = StIdle;
               end
            end else if ((MAX_HOLD != 0) && (hold_q >= MaxHold)) begin
               // Owner stays eligible but only wins if nobody else is waiting.
               ptr_d    = owner_nxt;
               forced_d = 1'b1;
               idx_d    = pick(req, owner_nxt);
               grant_d  = 8'h01 << idx_d;
               hold_d   = 8'd1;
            end else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= 3'd0;
         hold_q   <= 8'd0;
         grant_q  <= 8'h00;
         idx_q    <= 3'd0;
         forced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hold_q   <= hold_d;
         grant_q  <= grant_d;
         idx_q    <= idx_d;
         forced_q <= forced_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = (state_q == StBusy);
   assign forced_rel  = forced_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Sits in front of the 8-input one-hot encode path.
- Issues a registered one-hot grant plus its 3-bit encoded index.
- Holds the grant until the owner drops its request or a hold limit expires, then rotates priority.

Parameters:
- MAX_HOLD, 16, max consecutive cycles a grant is held while the owner keeps requesting. 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector, bit i = requester i.
- grant  output  8  one-hot grant, registered. All-zero when no owner.
- grant_idx  output  3  binary index of the set grant bit. Encoding: bit0->000 ... bit7->111. Value is 000 when grant_valid=0.
- grant_valid  output  1  high while a grant is active.
- forced_rel  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (rst=1 at clock edge) sets:
  - grant=0, grant_idx=000, grant_valid=0, forced_rel=0.
  - state=IDLE, priority pointer ptr=0, hold counter=0.
  - Reset overrides all other activity, including a grant in progress. The first grant can issue on the edge after rst deasserts.
- Arbitration function pick(v, p): the first set bit of v scanning p, p+1, ... modulo 8.
- States:
  - IDLE:
    - req==0: stay in IDLE, outputs zero.
    - Else: on the next edge, grant=onehot(pick(req,ptr)), grant_idx=pick, grant_valid=1, hold=1, go to BUSY.
    - Latency is one clock from req sampled to grant visible.
  - BUSY, owner o = grant_idx:
    - req[o]=1 and (MAX_HOLD=0 or hold<MAX_HOLD): keep the grant. hold increments, saturating at 255.
    - req[o]=0 (voluntary release): ptr<=o+1 mod 8.
      - If (req excluding o)!=0, hand over on the same edge to pick(req & ~onehot(o), o+1). hold=1, stay in BUSY. No idle gap.
      - Otherwise clear grant, grant_idx=000, grant_valid=0, go to IDLE.
    - req[o]=1 and hold==MAX_HOLD (MAX_HOLD>0) (forced release): forced_rel=1 for exactly one cycle. ptr<=o+1.
      - Re-arbitrate with pick(req, o+1). o is eligible, but only wins if no other requester is pending. hold=1, stay in BUSY.
      - If o is re-granted, grant stays continuously high, and forced_rel still pulses.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,...,7,0. No requester waits more than 7 grant tenures.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx always equals the encode of grant.
  - grant_valid equals (grant!=0).
- Requests arriving or leaving for non-owners never disturb the current grant.

Test Plan:
- Reset: drive req=8'hFF with rst=1 for 3 cycles -> grant=0, grant_idx=0, grant_valid=0 throughout. First cycle after release -> grant=8'h01, grant_idx=0.
- Single requester: req=8'h20 for 5 cycles, then 0 -> grant=8'h20 and grant_idx=101 from cycle 1 to cycle 5. Returns to 0 one cycle after req drops. forced_rel never asserts (MAX_HOLD=16).
- Rotation: req=8'hFF, each owner drops its bit for one cycle after 2 cycles of ownership -> grant_idx sequence 0,1,2,...,7,0 with back-to-back handover and grant_valid never low.
- Priority pointer wrap: owner 6 releases while req=8'h81 -> next grant is 7 (8'h80). After 7 releases -> grant 0.
- Hold limit: MAX_HOLD=4, req=8'h09 held constant -> owner 0 for 4 cycles, forced_rel pulse, then owner 3 for 4 cycles, pulse, then owner 0. With req=8'h01 only, grant stays 8'h01 continuously and forced_rel pulses every 4 cycles.
- Mid-grant reset: rst=1 while owner 5 is active -> grant clears on that edge. After release with req=8'hFF, grant goes to 0 (pointer reset), not 6.
